// File: rtl/uart_rx.sv
// UART receiver: two-flop line synchroniser, mid-bit sampling FSM, LSB-first
// shift register, optional parity and 1-2 checked stop bits.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int SAMPLES_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT        = (SAMPLES_PER_BIT - 1) / 2;
  localparam int CNT_W           = $clog2(SAMPLES_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_C      = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA_C = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP_C = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD     = (PARITY == 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_START = 5'b00010,
    S_DATA  = 5'b00100,
    S_PAR   = 5'b01000,
    S_STOP  = 5'b10000
  } state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_acc_q;
  logic                 par_err_q;
  logic                 rx_s;

  assign rx_s   = sync_q[1];
  assign o_busy = (state_q != S_IDLE);

  // NOTE: every register here is a flop, so all updates use <= to take the
  // pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      frame_acc_q  <= 1'b0;
      par_err_q    <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], i_rx};
      rx_prev_q    <= rx_s;
      o_data_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Edge-triggered so a line stuck low cannot start repeated frames.
          if (rx_prev_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == HALF_C) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == LAST_C) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_DATA_C) begin
              bit_q       <= '0;
              frame_acc_q <= 1'b0;
              par_err_q   <= 1'b0;
              state_q     <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PAR: begin
          if (cnt_q == LAST_C) begin
            cnt_q     <= '0;
            par_err_q <= ((^shift_q) ^ rx_s) != PAR_ODD;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == LAST_C) begin
            cnt_q <= '0;
            // Return to IDLE at mid stop bit so a back-to-back start edge is seen.
            if (bit_q == LAST_STOP_C) begin
              state_q      <= S_IDLE;
              o_data       <= shift_q;
              o_frame_err  <= frame_acc_q | ~rx_s;
              o_parity_err <= par_err_q;
              o_data_valid <= 1'b1;
            end else begin
              frame_acc_q <= frame_acc_q | ~rx_s;
              bit_q       <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
